// File: rtl/traffic_junction_ctrl.sv
// Junction signal controller: round-robin green allocation with yellow/all-red
// clearance and a maintenance flash mode. All outputs decode from registers.
module traffic_junction_ctrl #(
  parameter int N_WAYS    = 4,
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 16,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int FLASH_T   = 3,
  parameter int CNT_W     = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_WAYS-1:0]           sense,
  input  logic                        flash,
  output logic [3*N_WAYS-1:0]         lights,
  output logic [$clog2(N_WAYS)-1:0]   active_way,
  output logic [1:0]                  state
);

  localparam int AW = $clog2(N_WAYS);

  localparam logic [CNT_W-1:0] GMIN_C = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_C = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YEL_C  = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AR_C   = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] FL_C   = CNT_W'(FLASH_T - 1);

  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_DARK   = 3'b000;

  typedef enum logic [1:0] {
    ST_GREEN  = 2'b00,
    ST_YELLOW = 2'b01,
    ST_ALLRED = 2'b10,
    ST_FLASH  = 2'b11
  } phase_e;

  phase_e            state_q, state_d;
  logic [AW-1:0]     way_q, way_d;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic              blinkOn_q, blinkOn_d;
  logic              fromFlash_q, fromFlash_d;

  logic [N_WAYS-1:0] otherSense;
  logic              otherDemand;
  logic [AW-1:0]     rrWay;
  logic              found;
  logic              restart;
  int                idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_GREEN;
      way_q       <= '0;
      timer_q     <= '0;
      blinkOn_q   <= 1'b1;
      fromFlash_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      way_q       <= way_d;
      timer_q     <= timer_d;
      blinkOn_q   <= blinkOn_d;
      fromFlash_q <= fromFlash_d;
    end
  end

  // Round-robin search for the next demanding approach, skipping the current one.
  always_comb begin
    otherSense         = sense;
    otherSense[way_q]  = 1'b0;
    otherDemand        = |otherSense;
    rrWay              = (way_q == AW'(N_WAYS - 1)) ? '0 : way_q + AW'(1);
    found              = 1'b0;
    idx                = 0;
    for (int k = 1; k < N_WAYS; k++) begin
      idx = int'(way_q) + k;
      if (idx >= N_WAYS) idx = idx - N_WAYS;
      if (!found && sense[idx]) begin
        rrWay = AW'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    way_d       = way_q;
    blinkOn_d   = blinkOn_q;
    fromFlash_d = fromFlash_q;
    restart     = 1'b0;

    case (state_q)
      ST_GREEN: begin
        if (flash || (timer_q >= GMIN_C && otherDemand &&
                      (!sense[way_q] || timer_q >= GMAX_C)))
          state_d = ST_YELLOW;
      end
      ST_YELLOW: begin
        if (timer_q >= YEL_C)
          state_d = flash ? ST_FLASH : ST_ALLRED;
      end
      ST_ALLRED: begin
        if (flash) begin
          state_d = ST_FLASH;
        end else if (timer_q >= AR_C) begin
          state_d     = ST_GREEN;
          way_d       = fromFlash_q ? '0 : rrWay;
          fromFlash_d = 1'b0;
        end
      end
      ST_FLASH: begin
        // The timer doubles as the blink half-period counter while flashing.
        if (!flash) begin
          state_d     = ST_ALLRED;
          fromFlash_d = 1'b1;
        end else if (timer_q >= FL_C) begin
          blinkOn_d = ~blinkOn_q;
          restart   = 1'b1;
        end
      end
      default: state_d = ST_GREEN;
    endcase

    if (state_d == ST_FLASH && state_q != ST_FLASH)
      blinkOn_d = 1'b1;

    if (state_d != state_q || restart)
      timer_d = '0;
    else if (timer_q == {CNT_W{1'b1}})
      timer_d = timer_q;
    else
      timer_d = timer_q + CNT_W'(1);
  end

  always_comb begin
    logic [2:0] code;
    lights = '0;
    code   = LAMP_RED;
    for (int i = 0; i < N_WAYS; i++) begin
      code = LAMP_RED;
      case (state_q)
        ST_GREEN:  if (AW'(i) == way_q) code = LAMP_GREEN;
        ST_YELLOW: if (AW'(i) == way_q) code = LAMP_YELLOW;
        ST_ALLRED: code = LAMP_RED;
        ST_FLASH:  code = blinkOn_q ? LAMP_YELLOW : LAMP_DARK;
        default:   code = LAMP_RED;
      endcase
      lights[3*i +: 3] = code;
    end
  end

  assign active_way = way_q;
  assign state      = state_q;

endmodule

// File: tb/tb_traffic_junction_ctrl.sv
// Scoreboard bench for traffic_junction_ctrl: directed scenarios plus randomized
// traffic, compared cycle by cycle against a phase/age reference model.
module tb_traffic_junction_ctrl;

  localparam int N    = 3;
  localparam int GMIN = 4;
  localparam int GMAX = 8;
  localparam int YT   = 2;
  localparam int AT   = 1;
  localparam int FT   = 3;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   sense = '0;
  logic           flash = 1'b0;
  logic [3*N-1:0] lights;
  logic [1:0]     active_way;
  logic [1:0]     state;

  traffic_junction_ctrl #(
    .N_WAYS(N), .GREEN_MIN(GMIN), .GREEN_MAX(GMAX), .YELLOW_T(YT),
    .ALLRED_T(AT), .FLASH_T(FT), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .sense(sense), .flash(flash),
    .lights(lights), .active_way(active_way), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3*N-1:0] lights;
    logic [1:0]     way;
    logic [1:0]     phase;
  } exp_t;

  exp_t expQ[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: phase 0 green, 1 yellow, 2 all-red, 3 flash.
  int mPhase, mAge, mWay, mFlashAge;
  bit mAfterFlash;

  function automatic void check(string name, int act, int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic void modelReset();
    mPhase = 0; mAge = 0; mWay = 0; mFlashAge = 0; mAfterFlash = 0;
  endfunction

  function automatic int pickNext(logic [N-1:0] s);
    for (int k = 1; k < N; k++)
      if (s[(mWay + k) % N]) return (mWay + k) % N;
    return (mWay + 1) % N;
  endfunction

  function automatic void modelStep(logic [N-1:0] s, logic f);
    int np;
    bit other;
    np = mPhase;
    other = 0;
    for (int w = 0; w < N; w++)
      if (w != mWay && s[w]) other = 1;
    case (mPhase)
      0: if (f || (mAge + 1 >= GMIN && other && (!s[mWay] || mAge + 1 >= GMAX))) np = 1;
      1: if (mAge + 1 >= YT) np = f ? 3 : 2;
      2: if (f) np = 3;
         else if (mAge + 1 >= AT) begin
           np = 0;
           mWay = mAfterFlash ? 0 : pickNext(s);
           mAfterFlash = 0;
         end
      default: if (!f) begin np = 2; mAfterFlash = 1; end
    endcase
    if (np == 3) mFlashAge = (mPhase == 3) ? mFlashAge + 1 : 0;
    mAge = (np != mPhase) ? 0 : mAge + 1;
    mPhase = np;
  endfunction

  function automatic exp_t modelOut();
    exp_t e;
    logic [2:0] code;
    e.lights = '0;
    for (int i = 0; i < N; i++) begin
      case (mPhase)
        0: code = (i == mWay) ? 3'b001 : 3'b100;
        1: code = (i == mWay) ? 3'b010 : 3'b100;
        2: code = 3'b100;
        default: code = ((mFlashAge / FT) % 2 == 0) ? 3'b010 : 3'b000;
      endcase
      e.lights[3*i +: 3] = code;
    end
    e.way   = 2'(mWay);
    e.phase = 2'(mPhase);
    return e;
  endfunction

  task automatic applyStimulus(input logic [N-1:0] s, input logic f, input logic r);
    @(negedge clk);
    sense = s;
    flash = f;
    reset = r;
    if (r) modelReset();
    else   modelStep(s, f);
    expQ.push_back(modelOut());
  endtask

  task automatic checkOutput(input exp_t e);
    int greens;
    greens = 0;
    for (int i = 0; i < N; i++)
      if (lights[3*i +: 3] == 3'b001) greens++;
    check("lights", int'(lights), int'(e.lights));
    check("active_way", int'(active_way), int'(e.way));
    check("state", int'(state), int'(e.phase));
    check("twoGreens", int'(greens > 1), 0);
  endtask

  // Monitor: every cycle the DUT presents a new output set after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput(e);
    end
  end

  initial begin
    bit    hit;
    logic [N-1:0] rs;
    logic  rf;
    modelReset();

    repeat (2) @(negedge clk);
    check("resetLights", int'(lights), int'(9'b100_100_001));
    check("resetWay", int'(active_way), 0);
    check("resetState", int'(state), 0);

    // Idle junction holds way 0 green.
    applyStimulus(3'b000, 0, 1);
    repeat (50) applyStimulus(3'b000, 0, 0);

    // Single demand on way 2.
    applyStimulus(3'b000, 0, 1);
    repeat (12) applyStimulus(3'b100, 0, 0);

    // Full demand: max-length greens in order.
    applyStimulus(3'b000, 0, 1);
    repeat (45) applyStimulus(3'b111, 0, 0);

    // Skip way 1, then wrap to way 0.
    applyStimulus(3'b000, 0, 1);
    repeat (12) applyStimulus(3'b101, 0, 0);
    repeat (14) applyStimulus(3'b011, 0, 0);

    // Flash request during green, then release.
    applyStimulus(3'b000, 0, 1);
    applyStimulus(3'b000, 0, 0);
    repeat (20) applyStimulus(3'b000, 1, 0);
    repeat (8)  applyStimulus(3'b010, 0, 0);

    // Asynchronous reset in the first yellow cycle of way 1.
    applyStimulus(3'b000, 0, 1);
    hit = 0;
    for (int c = 0; c < 100 && !hit; c++) begin
      applyStimulus(3'b011, 0, 0);
      if (mPhase == 1 && mWay == 1) hit = 1;
    end
    check("yellowReached", int'(hit), 1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("asyncResetLights", int'(lights), int'(9'b100_100_001));
    check("asyncResetWay", int'(active_way), 0);
    check("asyncResetState", int'(state), 0);
    applyStimulus(3'b011, 0, 1);

    // Randomized traffic with occasional flash and reset.
    rs = 3'b000;
    rf = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) rs = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 59) == 0) rf = ~rf;
      applyStimulus(rs, rf, 1'($urandom_range(0, 299) == 0));
    end

    repeat (3) @(negedge clk);
    check("queueDrained", expQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/traffic_junction_ctrl.md
TRAFFIC_JUNCTION_CTRL -- requirements
Module: traffic_junction_ctrl

Interface
REQ-001 The block SHALL have parameter N_WAYS, default 4: number of approaches, legal range 2..8.
REQ-002 The block SHALL have parameter GREEN_MIN, default 4: minimum green cycles, at least 1.
REQ-003 The block SHALL have parameter GREEN_MAX, default 16: maximum green cycles under competing demand, at least GREEN_MIN.
REQ-004 The block SHALL have parameter YELLOW_T, default 2: yellow cycles, at least 1.
REQ-005 The block SHALL have parameter ALLRED_T, default 1: all-red clearance cycles, at least 1.
REQ-006 The block SHALL have parameter FLASH_T, default 3: flash half-period in cycles, at least 1.
REQ-007 The block SHALL have parameter CNT_W, default 8: timer width, wide enough for the largest timing parameter.
REQ-008 The block SHALL have port clk  input  1  clock, rising edge.
REQ-009 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-010 The block SHALL have port sense  input  N_WAYS  vehicle-present flag per approach, bit i = approach i.
REQ-011 The block SHALL have port flash  input  1  maintenance flash-mode request, level-sensitive.
REQ-012 The block SHALL have port lights  output  3*N_WAYS  per-approach lamp code in bits [3i+2:3i]: 001 green, 010 yellow, 100 red, 000 dark.
REQ-013 The block SHALL have port active_way  output  clog2(N_WAYS)  index of the approach owning the current green, yellow or all-red phase.
REQ-014 The block SHALL have port state  output  2  phase code: 00 GREEN, 01 YELLOW, 10 ALLRED, 11 FLASH.

Function
REQ-015 All outputs SHALL decode from registers only, with no combinational path from sense or flash.
REQ-016 A timer SHALL reset to 0 on every state entry, increment once per cycle, and saturate at its maximum.
REQ-017 In GREEN, approach active_way SHALL show 001 and every other approach SHALL show 100.
REQ-018 GREEN SHALL go to YELLOW at the edge where timer >= GREEN_MIN-1, some other approach has sense=1, and either sense[active_way]=0 or timer >= GREEN_MAX-1.
REQ-019 Without competing demand, GREEN SHALL hold indefinitely regardless of sense[active_way].
REQ-020 In YELLOW, approach active_way SHALL show 010 and all others SHALL show 100.
REQ-021 YELLOW SHALL last exactly YELLOW_T cycles and then go to ALLRED, or to FLASH if flash=1 at that edge.
REQ-022 In ALLRED, all approaches SHALL show 100, and the state SHALL last exactly ALLRED_T cycles.
REQ-023 At ALLRED exit, the next active_way SHALL be the first approach with sense=1 searching active_way+1, active_way+2, ... modulo N_WAYS, excluding the current way.
REQ-024 If no other approach has demand at ALLRED exit, the next active_way SHALL be active_way+1 modulo N_WAYS.
REQ-025 The round-robin search SHALL wrap from N_WAYS-1 to 0.
REQ-026 If flash=1 in GREEN, the block SHALL go to YELLOW at the next edge, overriding GREEN_MIN.
REQ-027 If flash=1 in ALLRED, the block SHALL go to FLASH at the next edge.
REQ-028 In FLASH, all approaches SHALL show 010 for FLASH_T cycles, then 000 for FLASH_T cycles, repeating, starting with 010.
REQ-029 In FLASH, active_way SHALL be held.
REQ-030 When flash=0 in FLASH, the block SHALL go to ALLRED with the timer cleared.
REQ-031 The ALLRED following FLASH SHALL select active_way 0.
REQ-032 If the exit conditions of REQ-018 and REQ-026 coincide, the block SHALL take the same YELLOW transition.
REQ-033 The lamp outputs SHALL never show 001 on two approaches in the same cycle.
REQ-034 A green SHALL always be preceded by at least ALLRED_T all-red cycles, except immediately after reset.

Reset
REQ-035 When reset=1, state SHALL be GREEN, active_way SHALL be 0, the timer SHALL be 0, and the flash blink phase SHALL be "on".
REQ-036 During reset, lights SHALL be approach 0 = 001 and all others = 100, taking effect asynchronously.
REQ-037 A reset asserted mid-YELLOW, mid-ALLRED or mid-FLASH SHALL abort the phase immediately, with no yellow or clearance sequence.

Verification (N_WAYS=3, GREEN_MIN=4, GREEN_MAX=8, YELLOW_T=2, ALLRED_T=1, FLASH_T=3)
REQ-038 The bench SHALL cover: reset, then sense=000 for 50 cycles -> lights=100_100_001 constant and active_way=0 throughout.
REQ-039 The bench SHALL cover: sense=100 from reset release -> 4 green cycles on way 0, 2 yellow, 1 all-red (100_100_100), then lights=001_100_100 with active_way=2.
REQ-040 The bench SHALL cover: sense=111 constant -> greens of 8 cycles each in order 0,1,2,0, each separated by 2 yellow and 1 all-red.
REQ-041 The bench SHALL cover: way 0 green with sense=101 -> next green is way 2 and way 1 is skipped; then sense=011 from way 2 -> wraps to way 0.
REQ-042 The bench SHALL cover: flash=1 in green cycle 1 -> 2 yellow, then 3 cycles of 010_010_010 and 3 cycles of 000_000_000 repeating; flash=0 -> 1 all-red cycle, then way 0 green.
REQ-043 The bench SHALL cover: reset pulse in yellow cycle 1 of way 1 -> same cycle, lights=100_100_001, active_way=0 and state=00; the bench checks no two-green cycle in every scenario.
